// File: rtl/button_wb_host_pkg.sv
// Shared types for the push-button LED host: FSM encoding, button indices
// and the press-to-state update rule.
package types;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } wb_host_state_t;

    localparam int NUM_BUTTONS = 4;
    localparam int BTN_INC     = 0;
    localparam int BTN_DEC     = 1;
    localparam int BTN_ROT     = 2;
    localparam int BTN_CLR     = 3;

    // Only the highest-priority event of a cycle is applied.
    function automatic logic [7:0] apply_press(input logic [7:0] cur, input logic [3:0] ev);
        logic [7:0] nxt;
        nxt = cur;
        if (ev[BTN_CLR]) begin
            nxt = 8'h00;
        end else if (ev[BTN_ROT]) begin
            nxt[7:4] = {cur[6:4], cur[7]};
        end else if (ev[BTN_DEC]) begin
            nxt[3:0] = cur[3:0] - 4'd1;
        end else if (ev[BTN_INC]) begin
            nxt[3:0] = cur[3:0] + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bus bundle with host and device views.
interface wishbone #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    logic             clk_i;
    logic             rst_i;
    logic [ADR_W-1:0] adr_o;
    logic [DAT_W-1:0] dat_o;
    logic [DAT_W-1:0] dat_i;
    logic             we_o;
    logic [DAT_W/8-1:0] sel_o;
    logic             stb_o;
    logic             cyc_o;
    logic             ack_i;
    logic             err_i;
    logic             rty_i;
    logic             stall_i;

    modport host (
        input  clk_i, rst_i, dat_i, ack_i, err_i, rty_i, stall_i,
        output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o
    );

    modport device (
        input  clk_i, rst_i, adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
        output dat_i, ack_i, err_i, rty_i, stall_i
    );
endinterface

// File: rtl/button_wb_host_debouncer.sv
// One button: two-flop synchroniser, stability counter, one-cycle pulse
// on each debounced rising edge.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic rise_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            rise_q <= 1'b0;
            // Any sample matching the current level restarts the count.
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/button_wb_host.sv
// Debounced push-buttons edit an LED state word; every change is pushed
// to the LED device with a single Wishbone write.
//   state    | meaning
//   IDLE     | bus quiet; starts a write when a state change is pending
//   REQ      | cyc+stb asserted until the device stops stalling
//   WAIT_ACK | cyc held, waiting for ack/err/rty or timeout
module button_wb_host
    import types::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          TIMEOUT_CYCLES  = 255,
    parameter logic [31:0] LED_ADDR        = 32'h0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] buttons_i,
    wishbone.host      wb,
    output logic [7:0] state_o,
    output logic       bus_error_o
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    wb_host_state_t fsm_q, fsm_d;
    logic [NUM_BUTTONS-1:0] press_ev;
    logic [7:0]       state_q, state_d;
    logic             pending_q, bus_error_q;
    logic [31:0]      dat_q, adr_q;
    logic             we_q;
    logic [3:0]       sel_q;
    logic [TMR_W-1:0] timer_q;
    logic             latch, load_timer, dec_timer, set_err, clr_err, cyc, stb, resp_ok;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .raw_i  (buttons_i[i]),
            .rise_o (press_ev[i])
        );
    end

    assign state_d = apply_press(state_q, press_ev);

    always_comb begin
        fsm_d      = fsm_q;
        latch      = 1'b0;
        load_timer = 1'b0;
        dec_timer  = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        cyc        = 1'b0;
        stb        = 1'b0;
        // A response counts in REQ only on the cycle the strobe is accepted.
        resp_ok    = (fsm_q == WAIT_ACK) || (fsm_q == REQ && !wb.stall_i);
        case (fsm_q)
            IDLE: begin
                if (pending_q) begin
                    latch      = 1'b1;
                    load_timer = 1'b1;
                    fsm_d      = REQ;
                end
            end
            REQ, WAIT_ACK: begin
                cyc = 1'b1;
                stb = (fsm_q == REQ);
                if (resp_ok && wb.ack_i) begin
                    fsm_d   = IDLE;
                    clr_err = 1'b1;
                end else if (resp_ok && wb.err_i) begin
                    fsm_d   = IDLE;
                    set_err = 1'b1;
                end else if (resp_ok && wb.rty_i) begin
                    fsm_d      = REQ;
                    load_timer = 1'b1;
                end else if (timer_q == '0) begin
                    fsm_d   = IDLE;
                    set_err = 1'b1;
                end else begin
                    dec_timer = 1'b1;
                    if (resp_ok) fsm_d = WAIT_ACK;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q       <= IDLE;
            state_q     <= 8'h00;
            pending_q   <= 1'b1;
            dat_q       <= '0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            timer_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            // A press in the latch cycle must still trigger a follow-up write.
            if (|press_ev) pending_q <= 1'b1;
            else if (latch) pending_q <= 1'b0;
            if (latch) begin
                dat_q <= {24'h0, state_q};
                adr_q <= LED_ADDR;
                we_q  <= 1'b1;
                sel_q <= '1;
            end
            if (load_timer) timer_q <= TMR_W'(TIMEOUT_CYCLES - 1);
            else if (dec_timer) timer_q <= timer_q - 1'b1;
            if (set_err) bus_error_q <= 1'b1;
            else if (clr_err) bus_error_q <= 1'b0;
        end
    end

    assign wb.cyc_o    = cyc;
    assign wb.stb_o    = stb;
    assign wb.we_o     = we_q;
    assign wb.sel_o    = sel_q;
    assign wb.adr_o    = adr_q;
    assign wb.dat_o    = dat_q;
    assign state_o     = state_q;
    assign bus_error_o = bus_error_q;
endmodule

// File: tb/tb_button_wb_host.sv
// Directed bench for button_wb_host with a scripted LED device on the bus.
module tb_button_wb_host;
    logic       clk_sys = 1'b0;
    logic       rst_ni;
    logic [3:0] buttons;
    logic [7:0] state;
    logic       bus_error;

    wishbone wb_bus ();

    always #5 clk_sys = ~clk_sys;
    assign wb_bus.clk_i = clk_sys;
    assign wb_bus.rst_i = ~rst_ni;

    button_wb_host #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (8),
        .LED_ADDR        (32'h40)
    ) dut (
        .clk_i       (clk_sys),
        .rst_ni      (rst_ni),
        .buttons_i   (buttons),
        .wb          (wb_bus),
        .state_o     (state),
        .bus_error_o (bus_error)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_cyc, n_stb, n_acc;
    logic [31:0] acc_dat [0:15];
    logic [31:0] last_adr;
    logic        last_we;
    logic [3:0]  last_sel;
    int          stall_left = 0;
    int          rty_left = 0;
    bit          silent = 1'b0;
    bit          acc_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        n_cyc = 0;
        n_stb = 0;
        n_acc = 0;
    endtask

    // One clock cycle: device responds one cycle after an accepted strobe.
    task automatic tick();
        @(negedge clk_sys);
        wb_bus.ack_i   = 1'b0;
        wb_bus.err_i   = 1'b0;
        wb_bus.rty_i   = 1'b0;
        wb_bus.stall_i = 1'b0;
        if (acc_prev && !silent) begin
            if (rty_left > 0) begin
                wb_bus.rty_i = 1'b1;
                rty_left--;
            end else begin
                wb_bus.ack_i = 1'b1;
            end
        end
        if (wb_bus.cyc_o && wb_bus.stb_o && stall_left > 0) begin
            wb_bus.stall_i = 1'b1;
            stall_left--;
        end
        acc_prev = wb_bus.cyc_o && wb_bus.stb_o && !wb_bus.stall_i;
        if (wb_bus.cyc_o) n_cyc++;
        if (wb_bus.cyc_o && wb_bus.stb_o) n_stb++;
        if (acc_prev) begin
            if (n_acc < 16) acc_dat[n_acc] = wb_bus.dat_o;
            last_adr = wb_bus.adr_o;
            last_we  = wb_bus.we_o;
            last_sel = wb_bus.sel_o;
            n_acc++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int idx);
        buttons[idx] = 1'b1;
        ticks(10);
        buttons[idx] = 1'b0;
        ticks(14);
    endtask

    task automatic preset(input logic [7:0] v);
        force dut.state_q = v;
        ticks(2);
        release dut.state_q;
        tick();
    endtask

    initial begin
        rst_ni = 1'b0;
        buttons = 4'h0;
        wb_bus.dat_i = '0;
        wb_bus.ack_i = 1'b0;
        wb_bus.err_i = 1'b0;
        wb_bus.rty_i = 1'b0;
        wb_bus.stall_i = 1'b0;
        clr_mon();
        ticks(3);
        check("rst_cyc", 32'(wb_bus.cyc_o), 32'h0);
        check("rst_stb", 32'(wb_bus.stb_o), 32'h0);
        check("rst_we", 32'(wb_bus.we_o), 32'h0);
        check("rst_dat", wb_bus.dat_o, 32'h0);
        check("rst_state", 32'(state), 32'h0);
        check("rst_err", 32'(bus_error), 32'h0);

        clr_mon();
        rst_ni = 1'b1;
        ticks(8);
        check("boot_cyc_cycles", n_cyc, 2);
        check("boot_stb_cycles", n_stb, 1);
        check("boot_writes", n_acc, 1);
        check("boot_dat", acc_dat[0], 32'h00);
        check("boot_adr", last_adr, 32'h40);
        check("boot_we", 32'(last_we), 32'h1);
        check("boot_sel", 32'(last_sel), 32'hF);
        check("boot_err", 32'(bus_error), 32'h0);

        clr_mon();
        press(0);
        check("inc1_state", 32'(state), 32'h01);
        check("inc1_dat", acc_dat[0], 32'h01);
        press(0);
        check("inc2_state", 32'(state), 32'h02);
        check("inc2_dat", acc_dat[1], 32'h02);
        press(0);
        check("inc3_state", 32'(state), 32'h03);
        check("inc3_dat", acc_dat[2], 32'h03);
        check("inc_writes", n_acc, 3);

        clr_mon();
        buttons[0] = 1'b1;
        ticks(3);
        buttons[0] = 1'b0;
        ticks(12);
        check("glitch_state", 32'(state), 32'h03);
        check("glitch_writes", n_acc, 0);

        preset(8'h10);
        clr_mon();
        press(2);
        check("rot1_state", 32'(state), 32'h20);
        check("rot1_dat", acc_dat[0], 32'h20);
        press(2);
        check("rot2_state", 32'(state), 32'h40);
        check("rot2_dat", acc_dat[1], 32'h40);

        preset(8'h0F);
        press(0);
        check("wrap_up_state", 32'(state), 32'h00);
        press(1);
        check("wrap_dn_state", 32'(state), 32'h0F);

        preset(8'h35);
        clr_mon();
        buttons = 4'b1001;
        ticks(10);
        buttons = 4'h0;
        ticks(14);
        check("prio_state", 32'(state), 32'h00);
        check("prio_writes", n_acc, 1);
        check("prio_dat", acc_dat[0], 32'h00);

        preset(8'h15);
        clr_mon();
        stall_left = 3;
        rty_left = 1;
        for (int c = 0; c < 40; c++) begin
            buttons[0] = (c < 10);
            buttons[2] = (c >= 3 && c < 13);
            buttons[1] = (c >= 5 && c < 15);
            tick();
        end
        buttons = 4'h0;
        ticks(4);
        check("stall_state", 32'(state), 32'h25);
        check("stall_stb_cycles", n_stb, 6);
        check("stall_cyc_cycles", n_cyc, 9);
        check("stall_writes", n_acc, 3);
        check("stall_dat0", acc_dat[0], 32'h16);
        check("stall_retry_dat", acc_dat[1], 32'h16);
        check("stall_follow_dat", acc_dat[2], 32'h25);

        silent = 1'b1;
        clr_mon();
        press(0);
        check("tmo_cyc_cycles", n_cyc, 8);
        check("tmo_writes", n_acc, 1);
        check("tmo_dat", acc_dat[0], 32'h26);
        check("tmo_err", 32'(bus_error), 32'h1);

        silent = 1'b0;
        clr_mon();
        press(0);
        check("clr_state", 32'(state), 32'h27);
        check("clr_writes", n_acc, 1);
        check("clr_err", 32'(bus_error), 32'h0);

        silent = 1'b1;
        buttons[0] = 1'b1;
        for (int i = 0; i < 30 && !(wb_bus.cyc_o && !wb_bus.stb_o); i++) tick();
        check("midrst_in_wait", 32'({wb_bus.cyc_o, wb_bus.stb_o}), 32'h2);
        rst_ni = 1'b0;
        buttons = 4'h0;
        tick();
        check("midrst_cyc", 32'(wb_bus.cyc_o), 32'h0);
        check("midrst_stb", 32'(wb_bus.stb_o), 32'h0);
        check("midrst_state", 32'(state), 32'h0);
        tick();
        silent = 1'b0;
        clr_mon();
        rst_ni = 1'b1;
        ticks(8);
        check("midrst_rewrite", n_acc, 1);
        check("midrst_rewrite_dat", acc_dat[0], 32'h00);
        check("midrst_err", 32'(bus_error), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/button_wb_host.md
BUTTON_WB_HOST -- requirements
Module: button_wb_host

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable samples a button needs before its debounced level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: cycles to wait for a bus response before aborting a write.
REQ-003 Parameter LED_ADDR, default 0: value driven on wb.adr_o for every write.
REQ-004 Port clk_i, input, 1: the only clock; all logic on its rising edge.
REQ-005 Port rst_ni, input, 1: reset, synchronous, active-low.
REQ-006 Port buttons_i, input, 4: raw asynchronous push-buttons, active-high.
REQ-007 Port wb, wishbone.host modport: bus host side, connected directly to the LED output device; the block does not use wb.clk_i/wb.rst_i.
REQ-008 Port state_o, output, 8: current LED state word; [3:0] green LEDs, [7:4] RGB enables.
REQ-009 Port bus_error_o, output, 1: sticky flag for the last write ending in err or timeout.

Function
REQ-010 Each button shall pass a 2-flop synchroniser, then a debouncer; debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples differing from it.
REQ-011 A press event is one cycle on a debounced 0->1 transition; releases generate no event.
REQ-012 Press actions on state_o: btn0 -> green nibble +1 mod 16; btn1 -> green nibble -1 mod 16; btn2 -> RGB nibble rotated left by 1; btn3 -> state_o = 0.
REQ-013 Simultaneous events in one cycle: priority btn3 > btn2 > btn1 > btn0; only the highest applies, the others are discarded.
REQ-014 Every state change sets pending; a write of the current state_o is issued whenever pending=1 and the FSM is IDLE.
REQ-015 FSM states IDLE, REQ, WAIT_ACK.
REQ-016 IDLE: cyc_o=stb_o=0; if pending, latch dat_o = {zero-extend, state_o}, we_o=1, sel_o all ones, adr_o=LED_ADDR, clear pending, go REQ next cycle.
REQ-017 REQ: cyc_o=stb_o=1; stays while wb.stall_i=1; on stall_i=0 go WAIT_ACK (stb asserted for exactly one unstalled cycle).
REQ-018 WAIT_ACK: cyc_o=1, stb_o=0; ack_i -> IDLE, clear bus_error_o; err_i -> IDLE, set bus_error_o; rty_i -> REQ with the same dat_o.
REQ-019 An ack/err/rty seen while still in REQ on the unstalled cycle shall be handled as in WAIT_ACK.
REQ-020 Timeout counter starts at REQ entry; at TIMEOUT_CYCLES without ack/err/rty, drop cyc_o, set bus_error_o, go IDLE.
REQ-021 Presses during REQ/WAIT_ACK update state_o immediately and set pending; multiple presses coalesce into one follow-up write of the newest state.
REQ-022 Minimum latency, press event to stb_o high: 2 cycles (pending set, then IDLE->REQ).

Reset
REQ-023 While rst_ni=0 at a clock edge: state_o=0, pending=1, FSM=IDLE, cyc_o=stb_o=we_o=0, dat_o=0, bus_error_o=0, debounced levels=0, counters=0.
REQ-024 Reset mid-transaction drops cyc_o/stb_o on that edge; after reset a write of 0x00 is issued so the LEDs match state_o.

Structure
REQ-025 Enum wb_host_state_t (IDLE, REQ, WAIT_ACK) and the button index constants shall go in package types.
REQ-026 Debounce shall be sub-module debouncer (1-bit, DEBOUNCE_CYCLES parameter, includes synchroniser), instantiated four times.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8, device acks 1 cycle after stb, stall=0)
REQ-027 Reset release -> one write of 0x00: cyc_o high for 2 cycles, stb_o for 1; bus_error_o=0.
REQ-028 btn0 held 10 cycles, 3 times -> state_o 0x01,0x02,0x03, three writes with matching dat_o; 3-cycle glitch -> no change.
REQ-029 state 0x10, btn2 pressed twice -> 0x20 then 0x40; btn0 at state 0x0F -> 0x00 (wrap); btn1 at 0x00 -> 0x0F.
REQ-030 btn0 and btn3 debounced in the same cycle at state 0x35 -> state 0x00, exactly one write.
REQ-031 Device stalls 3 cycles, then rty once, then ack; two presses during this -> stb_o held 4 cycles, retry with same data, then exactly one follow-up write of the final state.
REQ-032 Device never responds -> cyc_o drops after 8 cycles, bus_error_o=1; next acked write clears it; rst_ni low mid-WAIT_ACK -> cyc_o=0 next edge.
